// File: rtl/regfile_write_queue.sv
// Register-file write queue: buffers destination-register writes, retires one per
// cycle onto the single write port, and answers pending/forwarding lookups for decode.
module regfile_write_queue #(
    parameter int WordLen   = 32,
    parameter int WordCount = 32,
    parameter int Depth     = 4,
    localparam int RW = $clog2(WordCount),
    localparam int CW = $clog2(Depth + 1)
) (
    input  logic               clk,
    input  logic               rst,
    // Handshake: a request transfers on a rising edge where inValid && inReady.
    // inReady depends on count alone, so a same-cycle retire never frees a slot early.
    input  logic               inValid,
    output logic               inReady,
    input  logic [RW-1:0]      inRegister,
    input  logic [WordLen-1:0] inData,
    input  logic               drainEn,
    output logic               regWrite,
    output logic [RW-1:0]      writeRegister,
    output logic [WordLen-1:0] writeData,
    input  logic [RW-1:0]      queryReg1,
    input  logic [RW-1:0]      queryReg2,
    output logic               pending1,
    output logic               pending2,
    output logic [WordLen-1:0] fwdData1,
    output logic [WordLen-1:0] fwdData2,
    output logic [CW-1:0]      count
);
    localparam int PW = $clog2(Depth);

    logic [RW-1:0]      regArr  [Depth];
    logic [WordLen-1:0] dataArr [Depth];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic               push;
    logic               pop;

    assign inReady = (count < CW'(Depth));
    // Writes to r0 complete the handshake but are never stored.
    assign push = inValid && inReady && (inRegister != '0);
    assign pop  = drainEn && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head          <= head + 1'b1;
                regWrite      <= 1'b1;
                writeRegister <= regArr[head];
                writeData     <= dataArr[head];
            end else begin
                regWrite <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count/head/tail decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            regArr[tail]  <= inRegister;
            dataArr[tail] <= inData;
        end
    end

    // Oldest-to-youngest scan so the last hit wins; output stage is the oldest of all.
    function automatic logic [WordLen:0] lookup(input logic [RW-1:0] q);
        logic               hit;
        logic [WordLen-1:0] val;
        logic [PW-1:0]      idx;
        hit = 1'b0;
        val = '0;
        idx = '0;
        if (q != '0) begin
            if (regWrite && (writeRegister == q)) begin
                hit = 1'b1;
                val = writeData;
            end
            for (int k = 0; k < Depth; k++) begin
                idx = head + PW'(k);
                if ((k < int'(count)) && (regArr[idx] == q)) begin
                    hit = 1'b1;
                    val = dataArr[idx];
                end
            end
        end
        return {hit, val};
    endfunction

    always_comb begin
        {pending1, fwdData1} = lookup(queryReg1);
        {pending2, fwdData2} = lookup(queryReg2);
    end

endmodule
